// File: rtl/gcd_sched_pkg.sv
// Shared types and default sizing for the round-robin GCD engine scheduler.
package gcd_sched_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StLoadA,
        StLoadB,
        StWait,
        StResp
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after i_ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    int   w_j;
    logic w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(i_ptr) + k) % NREQ;
            if (!w_found && (((i_valid >> w_j) & NREQ'(1)) != '0)) begin
                w_found = 1'b1;
                o_grant = NREQ'(1) << w_j;
                o_idx   = IDXW'(w_j);
            end
        end
        o_any = |i_valid;
    end

endmodule

// File: rtl/gcd_share_sched.sv
// Shares one start/data_in/done subtractive GCD engine among NREQ requesters, round-robin,
// with zero-operand rejection and a WAIT timeout so a stuck engine cannot hang the block.
module gcd_share_sched
    import gcd_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    output logic [NREQ-1:0]       o_rsp_valid,
    output logic [WIDTH-1:0]      o_rsp_result,
    output logic                  o_rsp_error,
    output logic                  o_eng_start,
    output logic [WIDTH-1:0]      o_eng_data,
    input  logic                  i_eng_done,
    input  logic [WIDTH-1:0]      i_eng_result,
    output logic                  o_busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW-1:0]  r_gidx;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_req_ready;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_eng_data;
    logic             r_error;
    logic             r_eng_start;
    logic [CNTW-1:0]  r_cnt;

    logic [NREQ-1:0]  w_pick_gnt;
    logic [IDXW-1:0]  w_pick_idx;
    logic             w_pick_any;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .i_valid (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_sel_a = WIDTH'(i_req_a >> (int'(r_gidx) * WIDTH));
    assign w_sel_b = WIDTH'(i_req_b >> (int'(r_gidx) * WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_gnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_error     <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_data  <= '0;
            r_cnt       <= '0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_eng_start <= 1'b0;
            r_eng_data  <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_any) begin
                        r_gidx      <= w_pick_idx;
                        r_gnt       <= w_pick_gnt;
                        r_req_ready <= w_pick_gnt;
                        r_state     <= StGrant;
                    end
                end
                StGrant: begin
                    r_b <= w_sel_b;
                    // A zero operand would make the subtractive loop spin forever.
                    if ((w_sel_a == '0) || (w_sel_b == '0)) begin
                        r_result    <= '0;
                        r_error     <= 1'b1;
                        r_rsp_valid <= r_gnt;
                        r_state     <= StResp;
                    end else begin
                        r_eng_start <= 1'b1;
                        r_eng_data  <= w_sel_a;
                        r_state     <= StLoadA;
                    end
                end
                StLoadA: begin
                    r_eng_data <= r_b;
                    r_state    <= StLoadB;
                end
                StLoadB: begin
                    r_cnt   <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    // First WAIT cycle may still show done from the previous operation.
                    if ((r_cnt != '0) && i_eng_done) begin
                        r_result    <= i_eng_result;
                        r_error     <= 1'b0;
                        r_rsp_valid <= r_gnt;
                        r_state     <= StResp;
                    end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
                        r_result    <= '0;
                        r_error     <= 1'b1;
                        r_rsp_valid <= r_gnt;
                        r_state     <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StResp: begin
                    r_ptr    <= (r_gidx == IDXW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
                    r_result <= '0;
                    r_error  <= 1'b0;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_result;
    assign o_rsp_error  = r_error;
    assign o_eng_start  = r_eng_start;
    assign o_eng_data   = r_eng_data;
    assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_gcd_share_sched.sv
// Bench for gcd_share_sched: engine model, behavioural scoreboard and directed/random stimulus.
module tb_gcd_share_sched;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           rsp_error;
    logic           eng_start;
    logic [W-1:0]   eng_data;
    logic           eng_done = 1'b0;
    logic [W-1:0]   eng_result = '0;
    logic           busy;

    gcd_share_sched #(
        .WIDTH   (W),
        .NREQ    (N),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_result (rsp_result),
        .o_rsp_error  (rsp_error),
        .o_eng_start  (eng_start),
        .o_eng_data   (eng_data),
        .i_eng_done   (eng_done),
        .i_eng_result (eng_result),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Engine model: start+A, then B next cycle; done clears one cycle later (stale-done hazard).
    bit       eng_hang = 1'b0;
    int       e_state  = 0;
    int       e_cnt    = 0;
    int       e_starts = 0;
    logic [W-1:0] e_a = '0;
    logic [W-1:0] e_b = '0;

    always @(posedge clk) begin
        if (eng_start) begin
            e_a      <= eng_data;
            e_state  <= 1;
            e_starts <= e_starts + 1;
        end else if (e_state == 1) begin
            e_b     <= eng_data;
            e_cnt   <= int'($urandom_range(0, 8));
            e_state <= 2;
        end else if (e_state == 2) begin
            if (eng_hang) begin
                eng_done <= 1'b0;
            end else if (e_cnt == 0) begin
                eng_done   <= 1'b1;
                eng_result <= W'(gcd(int'(e_a), int'(e_b)));
                e_state    <= 0;
            end else begin
                eng_done <= 1'b0;
                e_cnt    <= e_cnt - 1;
            end
        end
    end

    // Scoreboard: one operation in flight, round-robin pointer advanced on each response.
    int           m_ptr = 0;
    bit           m_infl = 1'b0;
    int           m_idx = 0;
    int           m_a = 0;
    int           m_b = 0;
    bit           m_hang = 1'b0;
    int           m_starts = 0;
    int           m_st_cyc = 0;
    bit           m_lb = 1'b0;
    int           cyc = 0;
    logic [N-1:0] prev_valid = '0;

    always @(negedge clk) begin
        int  g;
        bit  zero;
        bit  exp_err;
        if (!rst_n) begin
            m_ptr  = 0;
            m_infl = 1'b0;
            m_lb   = 1'b0;
            chk("reset_outputs", {req_ready, rsp_valid, eng_start, eng_data, busy, rsp_error},
                '0);
        end else begin
            cyc++;
            if (req_ready != '0) begin
                chk("ready_while_busy", m_infl, 0);
                g = pick(prev_valid, m_ptr);
                chk("grant_pick", req_ready, (g < 0) ? 0 : (1 << g));
                if (g >= 0 && req_valid[g] && req_ready[g]) begin
                    m_infl   = 1'b1;
                    m_idx    = g;
                    m_a      = int'(req_a[g*W +: W]);
                    m_b      = int'(req_b[g*W +: W]);
                    m_hang   = eng_hang;
                    m_starts = 0;
                end
            end
            chk("busy", busy, m_infl);
            if (eng_start) begin
                m_starts++;
                m_st_cyc = cyc;
                chk("eng_data_a", eng_data, m_a);
                m_lb = 1'b1;
            end else if (m_lb) begin
                chk("eng_data_b", eng_data, m_b);
                m_lb = 1'b0;
            end else begin
                chk("eng_data_idle", eng_data, 0);
            end
            if (rsp_valid != '0) begin
                if (!m_infl) begin
                    chk("rsp_spurious", rsp_valid, 0);
                end else begin
                    zero    = (m_a == 0) || (m_b == 0);
                    exp_err = zero || m_hang;
                    chk("rsp_owner", rsp_valid, 1 << m_idx);
                    chk("rsp_error", rsp_error, exp_err);
                    if (!zero) chk("rsp_result", rsp_result, exp_err ? 0 : gcd(m_a, m_b));
                    chk("eng_start_count", m_starts, zero ? 0 : 1);
                    if (m_hang && !zero) chk("timeout_latency", cyc - m_st_cyc, TO + 2);
                    m_ptr  = (m_idx + 1) % N;
                    m_infl = 1'b0;
                end
            end
        end
        prev_valid = req_valid;
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_hs(input int idx);
        bit got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (req_valid[idx] && req_ready[idx]) got = 1'b1;
        end
        if (!got) chk("handshake_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int idx, output int err, output int res);
        bit got = 1'b0;
        err = -1;
        res = -1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid[idx]) begin
                got = 1'b1;
                err = int'(rsp_error);
                res = int'(rsp_result);
            end
        end
        if (!got) chk("response_timeout", 0, 1);
    endtask

    task automatic do_op(input int idx, input int a, input int b, output int err, output int res);
        @(posedge clk);
        #1;
        req_a[idx*W +: W] = W'(a);
        req_b[idx*W +: W] = W'(b);
        req_valid[idx]    = 1'b1;
        wait_hs(idx);
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
        wait_rsp(idx, err, res);
    endtask

    initial begin
        int err;
        int res;
        int s0;
        int order[5];
        int ng;
        logic [N-1:0] hs;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_eng_start", eng_start, 0);
        rst_n = 1'b1;

        // Single operation.
        do_op(0, 48, 18, err, res);
        chk("single_result", res, 6);
        chk("single_error", err, 0);
        chk("single_eng_a", e_a, 48);
        chk("single_eng_b", e_b, 18);

        // Fairness with all requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(12 * (i + 1));
            req_b[i*W +: W] = W'(8);
        end
        req_valid = '1;
        ng = 0;
        for (int n = 0; n < 400 && ng < 5; n++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            for (int i = 0; i < N; i++) if (hs[i]) begin
                order[ng] = i;
                ng++;
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        chk("fair_grants", ng, 5);
        for (int i = 0; i < 5; i++) chk("fair_order", order[i], i % N);
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);

        // Zero operand rejected without starting the engine.
        s0 = e_starts;
        do_op(2, 0, 35, err, res);
        chk("zero_error", err, 1);
        chk("zero_no_start", e_starts - s0, 0);

        // Engine never finishes: timeout.
        eng_hang = 1'b1;
        do_op(1, 9, 6, err, res);
        chk("timeout_error", err, 1);
        chk("timeout_result", res, 0);
        eng_hang = 1'b0;

        // Stale done from a previous op must not be taken as the new result.
        do_op(3, 40, 16, err, res);
        chk("stale_first", res, 8);
        do_op(0, 21, 14, err, res);
        chk("stale_result", res, 7);
        chk("stale_error", err, 0);

        // Requester that drops valid before being picked gets no grant.
        @(posedge clk);
        #1;
        req_a[0 +: W] = W'(50);
        req_b[0 +: W] = W'(20);
        req_valid[0]  = 1'b1;
        wait_hs(0);
        @(posedge clk);
        #1;
        req_valid[0]       = 1'b0;
        req_a[3*W +: W]    = W'(5);
        req_b[3*W +: W]    = W'(5);
        req_valid[3]       = 1'b1;
        repeat (2) @(posedge clk);
        #1 req_valid[3] = 1'b0;
        wait_rsp(0, err, res);
        chk("drop_owner_result", res, 10);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("drop_no_grant", req_ready, 0);
        end

        // Reset in the middle of WAIT aborts silently; next op is clean.
        eng_hang = 1'b1;
        @(posedge clk);
        #1;
        req_a[1*W +: W] = W'(100);
        req_b[1*W +: W] = W'(75);
        req_valid[1]    = 1'b1;
        wait_hs(1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        for (int n = 0; n < 50 && !eng_start; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp", rsp_valid, 0);
        chk("midrst_eng_data", eng_data, 0);
        eng_hang = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(1, 100, 75, err, res);
        chk("after_rst_result", res, 25);

        // Random traffic; scoreboard checks every response.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && n < 2500 && $urandom_range(0, 3) == 0) begin
                    req_a[i*W +: W] = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 300));
                    req_b[i*W +: W] = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 300));
                    req_valid[i]    = 1'b1;
                end
            end
            if (n >= 2500 && req_valid == '0 && !busy) break;
        end
        chk("drain_valid", req_valid, 0);
        repeat (20) @(negedge clk);
        chk("drain_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
